// File: rtl/dbus_mem_responder_pkg.sv
// Shared types and constants for the dbus memory responder: FSM states,
// request/response bundles and helpers that build them from flat ports.
package dbus_mem_responder_pkg;

  localparam int MEM_LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dbus_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  function automatic dbus_req_t pack_req(input logic        valid,
                                         input logic [31:0] addr,
                                         input logic [2:0]  size,
                                         input logic [3:0]  strobe,
                                         input logic [31:0] data);
    dbus_req_t r;
    r.valid  = valid;
    r.addr   = addr;
    r.size   = size;
    r.strobe = strobe;
    r.data   = data;
    return r;
  endfunction

  function automatic dbus_resp_t pack_resp(input logic        addr_ok,
                                           input logic        data_ok,
                                           input logic [31:0] data);
    dbus_resp_t r;
    r.addr_ok = addr_ok;
    r.data_ok = data_ok;
    r.data    = data;
    return r;
  endfunction

endpackage

// File: rtl/dbus_mem_responder_byte_ram.sv
// Single-port word RAM with four byte-lane write enables and a registered,
// enable-gated read port. Contents are not reset.
module dbus_mem_responder_byte_ram #(
  parameter int ADDR_BITS = 14,
  parameter     INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [3:0]           we,
  input  logic                 re,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dbus_mem_responder.sv
// Responder end of the core data bus: accepts one request, waits LATENCY
// cycles, then returns a one-cycle data_ok with read data (0 for writes).
module dbus_mem_responder
  import dbus_mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 14,
  parameter int LATENCY   = 2,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [3:0]  req_strobe,
  input  logic [31:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [31:0] resp_data
);

  // LATENCY must lie in 1..MEM_LATENCY_MAX; the counter is sized for the max.
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  dbus_req_t   req;
  dbus_resp_t  resp;
  dbus_state_e state_q;
  logic [3:0]           cnt_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic [3:0]           strobe_q;
  logic [31:0]          data_q;
  logic                 data_ok_q;
  logic                 rd_sel_q;
  logic                 enter_resp;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [3:0]           ram_we;
  logic [31:0]          ram_rdata;
  logic                 unused_bits;

  assign req         = pack_req(req_valid, req_addr, req_size, req_strobe, req_data);
  assign unused_bits = ^{req.size, req.addr};

  assign enter_resp = (state_q == IDLE && req.valid && LATENCY == 1) ||
                      (state_q == WAIT && cnt_q == 4'd1);

  // The read is issued on the edge entering RESP, so it sees any write that
  // retired at the end of an earlier RESP cycle.
  assign ram_addr = (state_q == IDLE) ? req.addr[ADDR_BITS+1:2] : idx_q;
  assign ram_we   = (state_q == RESP && resetn) ? strobe_q : 4'b0000;

  dbus_mem_responder_byte_ram #(
    .ADDR_BITS (ADDR_BITS),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .re    (enter_resp),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      strobe_q  <= '0;
      data_q    <= '0;
      data_ok_q <= 1'b0;
      rd_sel_q  <= 1'b0;
    end else begin
      data_ok_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req.valid) begin
            idx_q    <= req.addr[ADDR_BITS+1:2];
            strobe_q <= req.strobe;
            data_q   <= req.data;
            cnt_q    <= LAT_M1;
            if (LATENCY == 1) begin
              state_q   <= RESP;
              data_ok_q <= 1'b1;
              rd_sel_q  <= (req.strobe == 4'b0000);
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q   <= RESP;
            data_ok_q <= 1'b1;
            rd_sel_q  <= (strobe_q == 4'b0000);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // rd_sel_q and the RAM read register only change on RESP entry, so the
  // output holds its last value between responses.
  assign resp = pack_resp(resetn && state_q == IDLE && req.valid, data_ok_q,
                          rd_sel_q ? ram_rdata : 32'h0);

  assign resp_addr_ok = resp.addr_ok;
  assign resp_data_ok = resp.data_ok;
  assign resp_data    = resp.data;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Directed bench for dbus_mem_responder: three instances cover the default
// configuration, ADDR_BITS=4/LATENCY=1 and ADDR_BITS=4/LATENCY=15.
module tb_dbus_mem_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        v = 1'b0;
  int          sel = 0;
  logic [31:0] addr = '0;
  logic [2:0]  size = 3'd2;
  logic [3:0]  strobe = '0;
  logic [31:0] wdata = '0;

  logic        valid_a, valid_b, valid_c;
  logic        addr_ok_a, addr_ok_b, addr_ok_c;
  logic        data_ok_a, data_ok_b, data_ok_c;
  logic [31:0] data_a, data_b, data_c;
  logic        cur_addr_ok, cur_data_ok;
  logic [31:0] cur_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign valid_a = v && (sel == 0);
  assign valid_b = v && (sel == 1);
  assign valid_c = v && (sel == 2);
  assign cur_addr_ok = (sel == 0) ? addr_ok_a : (sel == 1) ? addr_ok_b : addr_ok_c;
  assign cur_data_ok = (sel == 0) ? data_ok_a : (sel == 1) ? data_ok_b : data_ok_c;
  assign cur_data    = (sel == 0) ? data_a    : (sel == 1) ? data_b    : data_c;

  dbus_mem_responder #(.ADDR_BITS(14), .LATENCY(2)) dut_a (
    .clk(clk), .resetn(resetn), .req_valid(valid_a), .req_addr(addr),
    .req_size(size), .req_strobe(strobe), .req_data(wdata),
    .resp_addr_ok(addr_ok_a), .resp_data_ok(data_ok_a), .resp_data(data_a));

  dbus_mem_responder #(.ADDR_BITS(4), .LATENCY(1)) dut_b (
    .clk(clk), .resetn(resetn), .req_valid(valid_b), .req_addr(addr),
    .req_size(size), .req_strobe(strobe), .req_data(wdata),
    .resp_addr_ok(addr_ok_b), .resp_data_ok(data_ok_b), .resp_data(data_b));

  dbus_mem_responder #(.ADDR_BITS(4), .LATENCY(15)) dut_c (
    .clk(clk), .resetn(resetn), .req_valid(valid_c), .req_addr(addr),
    .req_size(size), .req_strobe(strobe), .req_data(wdata),
    .resp_addr_ok(addr_ok_c), .resp_data_ok(data_ok_c), .resp_data(data_c));

  // Issue one request on the selected instance; lat is the number of cycles
  // from accept to data_ok, or -1 when a bound expires.
  task automatic do_txn(input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd,
                        output int lat);
    int cyc;
    lat = -1;
    rd  = 'x;
    @(negedge clk);
    addr = a; strobe = s; wdata = d; v = 1'b1;
    #1;
    cyc = 0;
    while (!cur_addr_ok && cyc < 40) begin
      @(negedge clk); #1; cyc++;
    end
    if (!cur_addr_ok) begin
      v = 1'b0;
      return;
    end
    @(negedge clk);
    v = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (cur_data_ok) begin
        lat = k;
        rd  = cur_data;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    resetn = 1'b0;
    v = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (addr_ok_a !== 1'b0) begin
      errors++; $display("FAIL reset_addr_ok: got %b want 0", addr_ok_a);
    end
    @(negedge clk);
    v = 1'b0;
    resetn = 1'b1;
    #1;
    checks++;
    if ({data_ok_a, data_ok_b, data_ok_c} !== 3'b000) begin
      errors++; $display("FAIL reset_data_ok: got %b want 000", {data_ok_a, data_ok_b, data_ok_c});
    end
    checks++;
    if (data_a !== 32'h0 || data_b !== 32'h0 || data_c !== 32'h0) begin
      errors++; $display("FAIL reset_resp_data: got %h %h %h want 0", data_a, data_b, data_c);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    int lat;
    sel = 0;
    do_txn(32'h100, 4'hF, 32'hDEADBEEF, rd, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL wr_resp_data: got %h want 00000000", rd); end
    do_txn(32'h100, 4'h0, 32'h0, rd, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_merge();
    logic [31:0] rd;
    int lat;
    sel = 0;
    do_txn(32'h40, 4'hF, 32'h11223344, rd, lat);
    do_txn(32'h40, 4'b0100, 32'h00AA0000, rd, lat);
    checks++;
    if (lat !== 2 || rd !== 32'h0) begin
      errors++; $display("FAIL merge_wr: got lat=%0d data=%h want lat=2 data=0", lat, rd);
    end
    do_txn(32'h40, 4'h0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h11AA3344) begin errors++; $display("FAIL merge_rd: got %h want 11aa3344", rd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ok_mask;
    logic [7:0]  dok_mask;
    logic [31:0] d0, d1;
    int n_ok, n_dok;
    sel = 0;
    ok_mask = '0; dok_mask = '0; n_ok = 0; n_dok = 0; d0 = '0; d1 = '0;
    @(negedge clk);
    addr = 32'h100; strobe = 4'h0; wdata = 32'h0; v = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (cur_addr_ok) begin ok_mask[k] = 1'b1; n_ok++; end
      if (cur_data_ok) begin
        dok_mask[k] = 1'b1;
        if (n_dok == 0) d0 = cur_data; else d1 = cur_data;
        n_dok++;
      end
      @(negedge clk);
      if (n_ok == 2) v = 1'b0;
    end
    v = 1'b0;
    checks++;
    if (ok_mask !== 8'b0000_1001) begin
      errors++; $display("FAIL b2b_addr_ok: got %b want 00001001", ok_mask);
    end
    checks++;
    if (dok_mask !== 8'b0010_0100) begin
      errors++; $display("FAIL b2b_data_ok: got %b want 00100100", dok_mask);
    end
    checks++;
    if (d0 !== 32'hDEADBEEF || d1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL b2b_data: got %h %h want deadbeef deadbeef", d0, d1);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    int lat;
    sel = 1;
    do_txn(32'h40, 4'hF, 32'h5, rd, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL wrap_wr_latency: got %0d want 1", lat); end
    do_txn(32'h00, 4'h0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h5) begin errors++; $display("FAIL wrap_rd: got %h want 00000005", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int lat, seen;
    sel = 0;
    seen = 0;
    @(negedge clk);
    addr = 32'h100; strobe = 4'hF; wdata = 32'h12345678; v = 1'b1;
    #1;
    checks++;
    if (cur_addr_ok !== 1'b1) begin errors++; $display("FAIL rstmid_accept: got %b want 1", cur_addr_ok); end
    @(negedge clk);
    v = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (cur_data_ok) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rstmid_data_ok: got %0d pulses want 0", seen); end
    do_txn(32'h100, 4'h0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rstmid_rd: got %h want deadbeef", rd); end
  endtask

  task automatic test_sweep(input int which, input int lat_exp);
    logic [31:0] model [16];
    logic [31:0] rd, exp_d, d, a;
    logic [3:0]  s;
    int lat;
    sel = which;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      a = {$urandom_range(0, 255), 6'b0} | 32'(i * 4);
      model[i] = d;
      do_txn(a, 4'hF, d, rd, lat);
      checks++;
      if (lat !== lat_exp) begin
        errors++; $display("FAIL sweep%0d_init_latency: got %0d want %0d", which, lat, lat_exp);
      end
    end
    for (int n = 0; n < 20; n++) begin
      a = $urandom;
      s = 4'($urandom_range(0, 15));
      d = $urandom;
      if (s == 4'h0) begin
        exp_d = model[a[5:2]];
      end else begin
        exp_d = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) model[a[5:2]][8*b +: 8] = d[8*b +: 8];
      end
      do_txn(a, s, d, rd, lat);
      checks++;
      if (lat !== lat_exp) begin
        errors++; $display("FAIL sweep%0d_latency: got %0d want %0d", which, lat, lat_exp);
      end
      checks++;
      if (rd !== exp_d) begin
        errors++; $display("FAIL sweep%0d_data: addr %h strobe %h got %h want %h", which, a, s, rd, exp_d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_merge();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_sweep(1, 1);
    test_sweep(2, 15);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
